// File: rtl/dmem_mmio.sv
// Data memory for the MIPS core: byte-enable word storage with combinational reads,
// plus a 16-byte I/O window holding a cycle counter, run status and a FINISH register.
module dmem_mmio #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 12,
  parameter logic [31:0] IO_BASE = 32'h0000_7FF0,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       a,
  input  logic [DATA_W-1:0] wd,
  input  logic              we,
  input  logic [3:0]        be,
  output logic [DATA_W-1:0] rd,
  output logic              done,
  output logic [DATA_W-1:0] exit_code,
  output logic              timeout,
  output logic [31:0]       cycles
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT) - 32'd1;

  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] exit_q, exit_d;
  logic [31:0]       cycles_q, cycles_d;

  logic              running;
  logic              is_io;
  logic              mem_we;
  logic              fin_wr;
  logic              wd_hit;
  logic [ADDR_W-1:0] widx;
  logic [DATA_W-1:0] mem_rd;
  logic              unused_ok;

  assign running   = !done_q && !timeout_q;
  assign is_io     = (a[31:4] == IO_BASE[31:4]);
  assign widx      = a[ADDR_W+1:2];
  assign mem_we    = we && running && !is_io;
  assign fin_wr    = we && running && is_io && (a[3:2] == 2'd3);
  assign wd_hit    = WD_EN && (cycles_q == WD_LAST);
  assign unused_ok = ^a[1:0];

  // One byte-wide array per lane so each be bit maps to an independent write port.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_q [DEPTH];

      always_ff @(posedge clk) begin
        if (mem_we && be[gi]) begin
          lane_q[widx] <= wd[8*gi +: 8];
        end
      end

      assign mem_rd[8*gi +: 8] = lane_q[widx];
    end
  endgenerate

  // A FINISH write on the watchdog edge takes priority; the counter advances either way.
  always_comb begin
    done_d    = done_q;
    timeout_d = timeout_q;
    exit_d    = exit_q;
    cycles_d  = cycles_q;
    if (running) begin
      cycles_d = cycles_q + 32'd1;
      if (fin_wr) begin
        done_d = 1'b1;
        exit_d = wd;
      end else if (wd_hit) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      exit_q    <= '0;
      cycles_q  <= '0;
    end else begin
      done_q    <= done_d;
      timeout_q <= timeout_d;
      exit_q    <= exit_d;
      cycles_q  <= cycles_d;
    end
  end

  always_comb begin
    rd = mem_rd;
    if (is_io) begin
      case (a[3:2])
        2'd0:    rd = cycles_q;
        2'd1:    rd = {30'b0, timeout_q, done_q};
        2'd2:    rd = '0;
        default: rd = exit_q;
      endcase
    end
  end

  assign done      = done_q;
  assign timeout   = timeout_q;
  assign exit_code = exit_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: a behavioural model of the memory and run state is checked
// against the DUT on every falling edge, plus hand-computed literal expectations.
module tb_dmem_mmio;

  localparam logic [31:0] IO_BASE = 32'h0000_7FF0;
  localparam int          TMO     = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a   = '0;
  logic [31:0] wd  = '0;
  logic        we  = 1'b0;
  logic [3:0]  be  = '0;
  logic [31:0] rd;
  logic        done;
  logic [31:0] exit_code;
  logic        timeout;
  logic [31:0] cycles;

  int tests  = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  dmem_mmio #(
    .DATA_W (32),
    .ADDR_W (12),
    .IO_BASE(IO_BASE),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .wd       (wd),
    .we       (we),
    .be       (be),
    .rd       (rd),
    .done     (done),
    .exit_code(exit_code),
    .timeout  (timeout),
    .cycles   (cycles)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [4096];
  bit          m_val [4096];
  logic        m_done    = 1'b0;
  logic        m_timeout = 1'b0;
  logic [31:0] m_exit    = '0;
  logic [31:0] m_cycles  = '0;

  wire         in_io   = (a[31:4] == IO_BASE[31:4]);
  wire  [11:0] key     = a[13:2];
  wire         fin_hit = we && in_io && (a[3:2] == 2'd3);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (en[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_done    <= 1'b0;
      m_timeout <= 1'b0;
      m_exit    <= '0;
      m_cycles  <= '0;
    end else if (!m_done && !m_timeout) begin
      m_cycles <= m_cycles + 1;
      if (fin_hit) begin
        m_done <= 1'b1;
        m_exit <= wd;
      end else if (m_cycles + 1 == TMO) begin
        m_timeout <= 1'b1;
      end
      if (we && !in_io && (be == 4'hF || (m_val[key] && be != 4'h0))) begin
        m_mem[key] <= merge(m_val[key] ? m_mem[key] : 32'h0, wd, be);
        m_val[key] <= 1'b1;
      end
    end
  end

  function automatic bit model_rd(input logic [31:0] addr, output logic [31:0] v);
    v = '0;
    if (addr[31:4] == IO_BASE[31:4]) begin
      case (addr[3:2])
        2'd0: v = m_cycles;
        2'd1: v = {30'b0, m_timeout, m_done};
        2'd2: v = 32'h0;
        default: v = m_exit;
      endcase
      return 1'b1;
    end
    v = m_mem[addr[13:2]];
    return m_val[addr[13:2]];
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] ev;
    if (cmp_en) begin
      chk("m_done",    {31'b0, done},    {31'b0, m_done});
      chk("m_timeout", {31'b0, timeout}, {31'b0, m_timeout});
      chk("m_exit",    exit_code,        m_exit);
      chk("m_cycles",  cycles,           m_cycles);
      if (model_rd(a, ev)) chk("m_rd", rd, ev);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] en);
    a = addr; wd = data; be = en; we = 1'b1;
    @(posedge clk);
    #2;
    we = 1'b0;
    $display("[TB] write a=%h wd=%h be=%b -> done=%0d exit=%h cycles=%0d",
             addr, data, en, done, exit_code, cycles);
  endtask

  task automatic read_chk(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    a = addr; we = 1'b0;
    #1;
    chk(nm, rd, exp);
    $display("[TB] read  a=%h rd=%h", addr, rd);
  endtask

  task automatic do_reset();
    we = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset_done",   {31'b0, done}, 32'h0);
    chk("reset_cycles", cycles,        32'h0);
    chk("reset_exit",   exit_code,     32'h0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // storage byte enables
    write(32'h0000_0000, 32'h0000_0077, 4'hF);
    write(32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    write(32'h0000_0100, 32'h0000_00AA, 4'b0001);
    read_chk(32'h0000_0100, 32'hDEAD_BEAA, "be_merge");
    write(32'h0000_0100, 32'h1234_5678, 4'b0000);
    read_chk(32'h0000_0100, 32'hDEAD_BEAA, "be_zero");

    // aliasing modulo 4096 words
    write(32'h0000_0004, 32'h0000_0011, 4'hF);
    read_chk(32'h0000_4004, 32'h0000_0011, "alias");

    // cycle counter and finish at edge 10
    do_reset();
    tick(5);
    read_chk(32'h0000_7FF0, 32'd5, "cycle5");
    tick(4);
    write(32'h0000_7FFC, 32'h0000_002A, 4'b0000);
    chk("fin_done",   {31'b0, done}, 32'h1);
    chk("fin_exit",   exit_code,     32'h2A);
    chk("fin_cycles", cycles,        32'd10);
    read_chk(32'h0000_7FF4, 32'h1,  "status_done");
    read_chk(32'h0000_7FFC, 32'h2A, "finish_rd");
    write(32'h0000_7FFC, 32'h0000_00FF, 4'hF);
    write(32'h0000_0000, 32'h0000_0005, 4'hF);
    chk("frozen_exit", exit_code, 32'h2A);
    read_chk(32'h0000_0000, 32'h0000_0077, "frozen_mem");
    tick(20);
    chk("frozen_cycles", cycles, 32'd10);

    // watchdog without finish
    do_reset();
    tick(49);
    chk("wd_pre_to",  {31'b0, timeout}, 32'h0);
    chk("wd_pre_cyc", cycles,           32'd49);
    tick(1);
    chk("wd_to",   {31'b0, timeout}, 32'h1);
    chk("wd_cyc",  cycles,           32'd50);
    chk("wd_done", {31'b0, done},    32'h0);
    read_chk(32'h0000_7FF4, 32'h2, "status_to");
    write(32'h0000_0100, 32'h0000_0000, 4'hF);
    read_chk(32'h0000_0100, 32'hDEAD_BEAA, "to_frozen_mem");

    // finish on the watchdog edge
    do_reset();
    tick(49);
    write(32'h0000_7FFC, 32'h0000_0033, 4'hF);
    chk("race_done", {31'b0, done},    32'h1);
    chk("race_to",   {31'b0, timeout}, 32'h0);
    chk("race_cyc",  cycles,           32'd50);
    chk("race_exit", exit_code,        32'h33);

    // asynchronous reset mid-run
    do_reset();
    write(32'h0000_0020, 32'h0000_CAFE, 4'hF);
    write(32'h0000_7FFC, 32'h0000_0007, 4'hF);
    chk("pre_rst_done", {31'b0, done}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("arst_done",   {31'b0, done},    32'h0);
    chk("arst_to",     {31'b0, timeout}, 32'h0);
    chk("arst_exit",   exit_code,        32'h0);
    chk("arst_cycles", cycles,           32'h0);
    read_chk(32'h0000_0020, 32'h0000_CAFE, "arst_mem");
    #2 rst = 1'b0;
    @(posedge clk);
    #2;
    chk("restart_cycles", cycles, 32'd1);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
